// File: rtl/nbit_mux_skid_stage_pkg.sv
// Shared definitions for the N-bit operand mux skid stage.
//   state_t   : skid FSM state (EMPTY, ONE, FULL), 2-bit encoding
//   sel_width : select width for a given source count, never below 1
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic int sel_width(input int num_src);
    int w;
    w = $clog2(num_src);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/nbit_mux_skid_stage_if.sv
// Handshake bundle between the operand-select logic and the execute stage.
//   in_data/in_sel/in_valid/in_ready : upstream side (NUM_SRC packed N-bit sources)
//   flush                            : synchronous pipeline flush
//   out_data/out_sel/out_valid/out_ready : downstream side
//   sel_err                          : only present when MUX_SEL_ERR_EN is defined
// Modports: master drives the upstream/downstream control, slave is the stage.
interface nbit_mux_skid_stage_if #(
  parameter int N       = 32,
  parameter int NUM_SRC = 4
) ();
  import mux_pkg::*;

  localparam int SEL_W = sel_width(NUM_SRC);

  logic [NUM_SRC*N-1:0] in_data;
  logic [SEL_W-1:0]     in_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic                 flush;
  logic [N-1:0]         out_data;
  logic [SEL_W-1:0]     out_sel;
  logic                 out_valid;
  logic                 out_ready;
`ifdef MUX_SEL_ERR_EN
  logic                 sel_err;
`endif

  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel, out_valid
`ifdef MUX_SEL_ERR_EN
    , input sel_err
`endif
  );

  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel, out_valid
`ifdef MUX_SEL_ERR_EN
    , output sel_err
`endif
  );

endinterface

// File: rtl/nbit_mux_skid_stage_mux.sv
// nbit_nx1_mux: combinational NUM_SRC-to-1 N-bit mux with binary select.
//   data    : packed sources, source k at [k*N +: N]
//   sel     : binary select
//   y       : selected source, all-zero when sel >= NUM_SRC
//   sel_err : high when sel >= NUM_SRC (only with MUX_SEL_ERR_EN)
module nbit_nx1_mux
  import mux_pkg::*;
#(
  parameter int N       = 32,
  parameter int NUM_SRC = 4,
  localparam int SEL_W  = sel_width(NUM_SRC)
) (
  input  logic [NUM_SRC*N-1:0] data,
  input  logic [SEL_W-1:0]     sel,
  output logic [N-1:0]         y
`ifdef MUX_SEL_ERR_EN
  , output logic               sel_err
`endif
);

  logic hit;

  // Explicit compare per source so out-of-range selects fall through to zero.
  always_comb begin
    y   = '0;
    hit = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        y   = data[k*N +: N];
        hit = 1'b1;
      end
    end
  end

`ifdef MUX_SEL_ERR_EN
  assign sel_err = ~hit;
`endif

endmodule

// File: rtl/nbit_mux_skid_stage.sv
// nbit_mux_skid_stage: operand mux registered into a 2-entry skid buffer.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nbit_mux_skid_stage_if (data, select, valid/ready, flush)
// Optional: MUX_SEL_ERR_EN adds a registered sel_err flag that travels with
// each entry through main/skid.
// in_ready and out_valid are dedicated flops loaded from the next state so
// they stay glitch-free; they always equal (state != FULL) / (state != EMPTY).
module nbit_mux_skid_stage
  import mux_pkg::*;
#(
  parameter int N       = 32,
  parameter int NUM_SRC = 4
) (
  input  logic clk,
  input  logic rst_n,
  nbit_mux_skid_stage_if.slave bus
);

  localparam int SEL_W = sel_width(NUM_SRC);

  state_t           state, next_state;
  logic [N-1:0]     sel_data;
  logic [N-1:0]     main_data, skid_data;
  logic [SEL_W-1:0] main_sel, skid_sel;
  logic             in_ready_q, out_valid_q;
  logic             accept, drain;
  logic             load_main_in, load_main_skid, load_skid;
`ifdef MUX_SEL_ERR_EN
  logic             sel_err_c, main_err, skid_err;
`endif

  nbit_nx1_mux #(
    .N       (N),
    .NUM_SRC (NUM_SRC)
  ) u_mux (
    .data    (bus.in_data),
    .sel     (bus.in_sel),
    .y       (sel_data)
`ifdef MUX_SEL_ERR_EN
    , .sel_err (sel_err_c)
`endif
  );

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = out_valid_q & bus.out_ready;

  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          next_state   = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          next_state = FULL;
        end else if (drain) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          load_main_skid = 1'b1;
          next_state     = ONE;
        end
      end
      default: next_state = EMPTY;
    endcase
    // Flush overrides everything; stored data is left as-is since it is
    // don't-care once out_valid drops.
    if (bus.flush) begin
      next_state     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_data   <= '0;
      main_sel    <= '0;
      skid_data   <= '0;
      skid_sel    <= '0;
`ifdef MUX_SEL_ERR_EN
      main_err    <= 1'b0;
      skid_err    <= 1'b0;
`endif
    end else begin
      state       <= next_state;
      in_ready_q  <= (next_state != FULL);
      out_valid_q <= (next_state != EMPTY);
      if (load_main_in) begin
        main_data <= sel_data;
        main_sel  <= bus.in_sel;
`ifdef MUX_SEL_ERR_EN
        main_err  <= sel_err_c;
`endif
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_sel  <= skid_sel;
`ifdef MUX_SEL_ERR_EN
        main_err  <= skid_err;
`endif
      end
      if (load_skid) begin
        skid_data <= sel_data;
        skid_sel  <= bus.in_sel;
`ifdef MUX_SEL_ERR_EN
        skid_err  <= sel_err_c;
`endif
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_data;
  assign bus.out_sel   = main_sel;
`ifdef MUX_SEL_ERR_EN
  assign bus.sel_err   = main_err & out_valid_q;
`endif

endmodule

// File: tb/tb_nbit_mux_skid_stage.sv
// Testbench for nbit_mux_skid_stage: a 4-source 32-bit instance driven by
// directed sequences and random traffic against a queue-based model, and a
// 3-source 8-bit instance exercised from a vector table (out-of-range select).
module tb_nbit_mux_skid_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  nbit_mux_skid_stage_if #(.N(32), .NUM_SRC(4)) if4 ();
  nbit_mux_skid_stage_if #(.N(8),  .NUM_SRC(3)) if3 ();

  nbit_mux_skid_stage #(.N(32), .NUM_SRC(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  nbit_mux_skid_stage #(.N(8), .NUM_SRC(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3)
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
  } entry_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  logic [31:0] srcs [4];
  entry_t      q4 [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_srcs();
    if4.in_data = {srcs[3], srcs[2], srcs[1], srcs[0]};
  endtask

  // Outputs against the model: valid whenever something is queued, ready
  // while fewer than two entries are held, head of queue on the data bus.
  task automatic check4(input string tag);
    chk({tag, ".out_valid"}, 64'(if4.out_valid), 64'(q4.size() > 0));
    chk({tag, ".in_ready"},  64'(if4.in_ready),  64'(q4.size() < 2));
    if (q4.size() > 0) begin
      chk({tag, ".out_data"}, 64'(if4.out_data), 64'(q4[0].d));
      chk({tag, ".out_sel"},  64'(if4.out_sel),  64'(q4[0].s));
    end
  endtask

  // One clock of the 4-source instance with model update and check.
  task automatic tick4(input string tag);
    bit     acc, drn, fl;
    entry_t e;
    acc = (if4.in_valid === 1'b1) && (q4.size() < 2);
    drn = (q4.size() > 0) && (if4.out_ready === 1'b1);
    fl  = (if4.flush === 1'b1);
    e.d = srcs[if4.in_sel];
    e.s = if4.in_sel;
    @(posedge clk);
    #1;
    if (fl) begin
      q4.delete();
    end else begin
      if (drn) void'(q4.pop_front());
      if (acc) q4.push_back(e);
    end
    check4(tag);
  endtask

  initial begin
    vec_t tbl [6];
    int   delivered;

    checks   = 0;
    failures = 0;

    tbl[0] = '{sel: 2'd0, exp_data: 8'hA1, exp_err: 1'b0};
    tbl[1] = '{sel: 2'd1, exp_data: 8'hB2, exp_err: 1'b0};
    tbl[2] = '{sel: 2'd2, exp_data: 8'hC3, exp_err: 1'b0};
    tbl[3] = '{sel: 2'd3, exp_data: 8'h00, exp_err: 1'b1};
    tbl[4] = '{sel: 2'd2, exp_data: 8'hC3, exp_err: 1'b0};
    tbl[5] = '{sel: 2'd3, exp_data: 8'h00, exp_err: 1'b1};

    rst_n         = 1'b0;
    srcs[0]       = 32'h11111111;
    srcs[1]       = 32'h22222222;
    srcs[2]       = 32'h33333333;
    srcs[3]       = 32'h44444444;
    drive_srcs();
    if4.in_sel    = '0;
    if4.in_valid  = 1'b0;
    if4.flush     = 1'b0;
    if4.out_ready = 1'b1;
    if3.in_data   = {8'hC3, 8'hB2, 8'hA1};
    if3.in_sel    = '0;
    if3.in_valid  = 1'b0;
    if3.flush     = 1'b0;
    if3.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 64'(if4.out_valid), 64'(0));
    chk("rst.in_ready",  64'(if4.in_ready),  64'(1));
    chk("rst.out_data",  64'(if4.out_data),  64'(0));
    chk("rst.out_sel",   64'(if4.out_sel),   64'(0));
    chk("rst3.out_valid", 64'(if3.out_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic: one accept of source 2
    if4.in_sel   = 2'd2;
    if4.in_valid = 1'b1;
    tick4("basic.acc");
    if4.in_valid = 1'b0;
    chk("basic.data",     64'(if4.out_data),  64'h33333333);
    chk("basic.sel",      64'(if4.out_sel),   64'(2));
    chk("basic.valid",    64'(if4.out_valid), 64'(1));
    chk("basic.in_ready", 64'(if4.in_ready),  64'(1));
    tick4("basic.drain");
    chk("basic.empty", 64'(if4.out_valid), 64'(0));

    // Backpressure: fill both entries, hold, then drain in order
    if4.out_ready = 1'b0;
    if4.in_valid  = 1'b1;
    if4.in_sel    = 2'd0;
    tick4("bp.acc0");
    if4.in_sel    = 2'd3;
    tick4("bp.acc3");
    if4.in_valid  = 1'b0;
    chk("bp.in_ready", 64'(if4.in_ready), 64'(0));
    chk("bp.head",     64'(if4.out_data), 64'h11111111);
    tick4("bp.hold");
    chk("bp.hold_data", 64'(if4.out_data), 64'h11111111);
    if4.out_ready = 1'b1;
    tick4("bp.drain0");
    chk("bp.second",    64'(if4.out_data), 64'h44444444);
    chk("bp.ready_bk",  64'(if4.in_ready), 64'(1));
    tick4("bp.drain3");
    chk("bp.empty", 64'(if4.out_valid), 64'(0));

    // Streaming: 16 accepts back to back, count deliveries
    delivered = 0;
    for (int i = 0; i < 17; i++) begin
      if4.in_valid = (i < 16);
      if4.in_sel   = 2'(i % 4);
      if (if4.out_valid === 1'b1) delivered++;
      tick4("stream");
    end
    if4.in_valid = 1'b0;
    chk("stream.count", 64'(delivered), 64'(16));

    // Flush while FULL with a concurrent accept
    if4.out_ready = 1'b0;
    if4.in_valid  = 1'b1;
    if4.in_sel    = 2'd1;
    tick4("fl.acc1");
    if4.in_sel    = 2'd2;
    tick4("fl.acc2");
    chk("fl.full", 64'(if4.in_ready), 64'(0));
    if4.flush     = 1'b1;
    if4.in_sel    = 2'd0;
    tick4("fl.flush");
    if4.flush     = 1'b0;
    if4.in_valid  = 1'b0;
    chk("fl.valid", 64'(if4.out_valid), 64'(0));
    chk("fl.ready", 64'(if4.in_ready),  64'(1));
    if4.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick4("fl.after");

    // Asynchronous reset while FULL
    if4.out_ready = 1'b0;
    if4.in_valid  = 1'b1;
    if4.in_sel    = 2'd3;
    tick4("ar.acc0");
    tick4("ar.acc1");
    if4.in_valid  = 1'b0;
    chk("ar.full", 64'(if4.in_ready), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.valid", 64'(if4.out_valid), 64'(0));
    chk("ar.ready", 64'(if4.in_ready),  64'(1));
    q4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    if4.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick4("ar.idle");

    // Vector table on the 3-source instance, including out-of-range select
    for (int i = 0; i < 6; i++) begin
      if3.in_sel   = tbl[i].sel;
      if3.in_valid = 1'b1;
      @(posedge clk);
      #1;
      if3.in_valid = 1'b0;
      chk($sformatf("tbl%0d.valid", i), 64'(if3.out_valid), 64'(1));
      chk($sformatf("tbl%0d.data", i),  64'(if3.out_data),  64'(tbl[i].exp_data));
      chk($sformatf("tbl%0d.sel", i),   64'(if3.out_sel),   64'(tbl[i].sel));
`ifdef MUX_SEL_ERR_EN
      chk($sformatf("tbl%0d.err", i),   64'(if3.sel_err),   64'(tbl[i].exp_err));
`endif
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.drained", i), 64'(if3.out_valid), 64'(0));
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) srcs[k] = $urandom;
      drive_srcs();
      if4.in_valid  = ($urandom_range(0, 3) != 0);
      if4.in_sel    = 2'($urandom_range(0, 3));
      if4.out_ready = ($urandom_range(0, 2) != 0);
      if4.flush     = ($urandom_range(0, 15) == 0);
      tick4("rand");
    end
    if4.in_valid = 1'b0;
    if4.flush    = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nbit_mux_skid_stage.md
Name: nbit_mux_skid_stage

Overview:
- Parametrised successor to the fixed 4-input N-bit operand mux.
- Selects one of NUM_SRC N-bit sources with a binary select and registers the result into a 2-entry skid buffer with a valid/ready handshake.
- Sits between the forwarding/operand-select logic and the execute stage, so the mux output becomes a pipeline stage that tolerates downstream stalls without losing data.

Parameters:
- N, 32, data width of each source and of the output.
- NUM_SRC, 4, number of sources; minimum 2.
- SEL_W, $clog2(NUM_SRC), select width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_SRC*N  packed sources; source k occupies bits [k*N +: N].
- in_sel  input  SEL_W  binary select.
- in_valid  input  1  upstream holds data/select valid.
- in_ready  output  1  stage can accept; registered.
- flush  input  1  synchronous pipeline flush.
- out_data  output  N  selected, registered data.
- out_sel  output  SEL_W  select value that produced out_data.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- The single clock is clk. Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=EMPTY; out_valid=0; out_data=0; out_sel=0; in_ready=1; skid register cleared.
- Select function (combinational):
  - sel_data = source[in_sel] when in_sel < NUM_SRC.
  - sel_data = all-zero for in_sel >= NUM_SRC (only reachable when NUM_SRC is not a power of 2).
- Transfers:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
- Latency: data accepted at edge t appears on out_data with out_valid=1 after edge t (1 cycle) when the stage is not full.
- State machine:
  - EMPTY: main and skid empty.
    - accept -> main<=sel_data, go to ONE.
    - Otherwise stay.
  - ONE: main valid.
    - accept & drain -> main<=new data, stay ONE.
    - accept & !drain -> skid<=new data, go to FULL.
    - !accept & drain -> go to EMPTY.
    - Otherwise hold.
  - FULL: main and skid valid; in_ready=0.
    - drain -> main<=skid, go to ONE.
    - Otherwise hold.
- in_ready is registered: it is 0 exactly in the cycles when state==FULL.
- Ordering: strictly in order; the skid entry is never overtaken.
- Flush:
  - Synchronous and highest priority. Next state is EMPTY and out_valid=0 regardless of accept or drain in the same cycle.
  - Data accepted in the flush cycle is discarded.
  - out_data/out_sel are not cleared by flush; they are don't-care while out_valid=0.
- Hold: while out_valid=1 and out_ready=0, out_data and out_sel must not change.
- Reset mid-transfer: all buffered data is lost; no out_valid pulse after reset deasserts until a new accept.

Optional Feature:
- Macro: MUX_SEL_ERR_EN.
- Defined:
  - Adds output port sel_err (1 bit, reset 0).
  - sel_err is registered alongside the data and travels with its entry through main/skid.
  - sel_err=1 with out_valid=1 when the delivered entry was accepted with in_sel >= NUM_SRC.
- Undefined:
  - Port and storage are absent.
  - Out-of-range selects silently yield zero.

Decomposition:
- Shared package mux_pkg holds:
  - the state enum (EMPTY, ONE, FULL) with a 2-bit encoding;
  - a sel_width function wrapping $clog2 with a minimum of 1.
- One natural combinational sub-module, nbit_nx1_mux (params N, NUM_SRC), which produces sel_data with the zero-on-out-of-range rule.
- The top level contains only the skid FSM and the registers.

Test Plan:
- Reset/basic:
  - Stimulus: rst_n low then high; N=32, NUM_SRC=4; sources 0x11111111/0x22222222/0x33333333/0x44444444; in_sel=2, in_valid for 1 cycle; out_ready=1.
  - Required: out_data=0x33333333, out_sel=2, out_valid=1 exactly one cycle after accept; in_ready stays 1.
- Backpressure:
  - Stimulus: out_ready=0; accept sel=0 then sel=3 on consecutive cycles.
  - Required: in_ready=0 from the next cycle; out_data holds 0x11111111. Then raise out_ready: 0x11111111 is delivered, then 0x44444444, and in_ready returns to 1.
- Streaming:
  - Stimulus: in_valid=1 and out_ready=1 continuously with sel cycling 0..3 for 16 cycles.
  - Required: 16 outputs in order, one per cycle, no bubbles after the first.
- Flush:
  - Stimulus: enter FULL; assert flush together with in_valid=1.
  - Required: next cycle out_valid=0, in_ready=1; the flushed and the concurrent inputs never appear.
- Out of range:
  - Stimulus: NUM_SRC=3, in_sel=3.
  - Required: out_data=0; with MUX_SEL_ERR_EN, sel_err=1 only on that entry.
- Async reset mid-operation:
  - Stimulus: drop rst_n mid-clock while FULL.
  - Required: out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
